// File: rtl/triangle_frame_buffer.sv
// Ping-pong triangle frame buffer between projector and rasterizer.
// Optional stats (frames_dropped, peak_count) enabled by TRI_BUF_STATS_EN.
module triangle_frame_buffer #(
  parameter int DEPTH = 256,
  parameter int TRI_W = 160,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TRI_W-1:0] tri_in,
  input  logic             tri_in_valid,
  input  logic             proj_done,
  output logic             frame_start,
  output logic [CW-1:0]    rd_count,
  input  logic             rd_req,
  output logic [TRI_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  output logic             wr_sealed,
  output logic             overflow,
  output logic [15:0]      frames_dropped,
  output logic [CW-1:0]    peak_count
);

  typedef enum logic {W_FILL, W_SEALED} wr_state_e;
  typedef enum logic {R_IDLE, R_SERVING} rd_state_e;

  wr_state_e wr_state, wr_state_d;
  rd_state_e rd_state, rd_state_d;

  logic [TRI_W-1:0] mem [2*DEPTH];

  logic          wr_bank;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_ptr;
  logic          done_q;

  logic done_rise;
  logic wr_full;
  logic wr_en;
  logic rd_accept;
  logic rd_done;
  logic swap;

  assign done_rise = proj_done & ~done_q;
  assign wr_full   = (wr_cnt == CW'(DEPTH));
  assign wr_en     = (wr_state == W_FILL) && tri_in_valid && !wr_full;
  assign rd_accept = (rd_state == R_SERVING) && rd_req
                     && (rd_ptr != rd_count);
  // Bank frees once the last word is on the output (or at once if empty)
  assign rd_done   = (rd_state == R_SERVING) && (rd_ptr == rd_count)
                     && (rd_valid || (rd_count == '0));
  assign swap      = (wr_state == W_SEALED)
                     && ((rd_state == R_IDLE) || rd_done);
  assign wr_sealed = (wr_state == W_SEALED);

  always_comb begin
    wr_state_d = wr_state;
    rd_state_d = rd_state;
    if (swap)
      wr_state_d = W_FILL;
    else if ((wr_state == W_FILL) && done_rise)
      wr_state_d = W_SEALED;
    if (swap)
      rd_state_d = R_SERVING;
    else if (rd_done)
      rd_state_d = R_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state <= W_FILL;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_d;
      rd_state <= rd_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q      <= 1'b0;
      wr_bank     <= 1'b0;
      wr_cnt      <= '0;
      overflow    <= 1'b0;
      rd_count    <= '0;
      rd_ptr      <= '0;
      frame_start <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      done_q      <= proj_done;
      frame_start <= swap;
      rd_valid    <= rd_accept;
      rd_last     <= rd_accept && ((rd_ptr + 1'b1) == rd_count);
      if (wr_en)
        wr_cnt <= wr_cnt + 1'b1;
      if ((wr_state == W_FILL) && tri_in_valid && wr_full)
        overflow <= 1'b1;
      if (rd_accept)
        rd_ptr <= rd_ptr + 1'b1;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        rd_count <= wr_cnt;
        rd_ptr   <= '0;
        wr_cnt   <= '0;
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wr_bank, wr_cnt[AW-1:0]}] <= tri_in;
  end

  // Read bank is always the one the writer is not filling
  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_data <= '0;
    else if (rd_accept)
      rd_data <= mem[{~wr_bank, rd_ptr[AW-1:0]}];
  end

`ifdef TRI_BUF_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frames_dropped <= '0;
      peak_count     <= '0;
    end else begin
      if ((wr_state == W_SEALED) && done_rise
          && (frames_dropped != 16'hFFFF))
        frames_dropped <= frames_dropped + 16'd1;
      if (swap && (wr_cnt > peak_count))
        peak_count <= wr_cnt;
    end
  end
`else
  assign frames_dropped = '0;
  assign peak_count     = '0;
`endif

endmodule
